// File: rtl/lcd_timing_pkg.sv
// Shared 800x480 panel timing constants and control-line bundle.
// The character renderer imports this same package.
package lcd_timing_pkg;

    localparam int unsigned H_ACTIVE = 800;
    localparam int unsigned H_FRONT  = 210;
    localparam int unsigned H_SYNC   = 1;
    localparam int unsigned H_BACK   = 45;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FRONT  = 22;
    localparam int unsigned V_SYNC   = 1;
    localparam int unsigned V_BACK   = 22;
    localparam int unsigned LAT      = 2;

    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int unsigned H_START = H_SYNC + H_BACK;
    localparam int unsigned V_START = V_SYNC + V_BACK;

    localparam int unsigned X_W = 10;
    localparam int unsigned Y_W = 9;
    localparam int unsigned H_W = 11;
    localparam int unsigned V_W = 10;

    // Panel control lines as they travel through the alignment delay line.
    typedef struct packed {
        logic hd;
        logic vd;
        logic den;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{hd: 1'b1, vd: 1'b1, den: 1'b0};

endpackage

// File: rtl/lcd_delay_line.sv
// Depth x width shift register with clock enable and a reset fill value.
// DEPTH=0 is a straight wire.
module lcd_delay_line #(
    parameter int unsigned      DEPTH = 2,
    parameter int unsigned      WIDTH = 3,
    parameter logic [WIDTH-1:0] FILL  = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_bypass;
            assign unused_bypass = clk_i ^ rst_i ^ en_i;
            assign q_o = d_i;
        end else begin : g_shift
            logic [WIDTH-1:0] stage_q [DEPTH];

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= FILL;
                    end
                end else if (en_i) begin
                    stage_q[0] <= d_i;
                    for (int unsigned i = 1; i < DEPTH; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign q_o = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/lcd_timing_gen.sv
// Pixel clock and raster timing for the parallel-RGB panel; HD/VD/DEN are
// delayed by the renderer latency so they line up with its pixel output.
module lcd_timing_gen
    import lcd_timing_pkg::*;
#(
    parameter int unsigned T_H_ACTIVE = H_ACTIVE,
    parameter int unsigned T_H_FRONT  = H_FRONT,
    parameter int unsigned T_H_SYNC   = H_SYNC,
    parameter int unsigned T_H_BACK   = H_BACK,
    parameter int unsigned T_V_ACTIVE = V_ACTIVE,
    parameter int unsigned T_V_FRONT  = V_FRONT,
    parameter int unsigned T_V_SYNC   = V_SYNC,
    parameter int unsigned T_V_BACK   = V_BACK,
    parameter int unsigned T_LAT      = LAT
) (
    input  logic           CLK,
    input  logic           RST,
    output logic           NCLK,
    output logic           PIX_EN,
    output logic           GREST,
    output logic           HD,
    output logic           VD,
    output logic           DEN,
    output logic           REQ,
    output logic [X_W-1:0] X,
    output logic [Y_W-1:0] Y,
    output logic           FRAME
);

    localparam int unsigned H_TOT = T_H_SYNC + T_H_BACK + T_H_ACTIVE + T_H_FRONT;
    localparam int unsigned V_TOT = T_V_SYNC + T_V_BACK + T_V_ACTIVE + T_V_FRONT;
    localparam int unsigned H_ST  = T_H_SYNC + T_H_BACK;
    localparam int unsigned V_ST  = T_V_SYNC + T_V_BACK;

    logic           ph_q;
    logic           grest_q;
    logic [H_W-1:0] h_q, h_d;
    logic [V_W-1:0] v_q, v_d;
    logic           hd_e_q, hd_e_d;
    logic           vd_e_q, vd_e_d;
    logic           req_q, req_d;
    logic           frame_q, frame_d;
    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic           h_last, v_last;
    ctrl_t          early, late;

    // Early signals describe the pixel the counters point at; the counters
    // move on to the next pixel on the same tick.
    always_comb begin
        h_last  = (h_q == H_W'(H_TOT - 1));
        v_last  = (v_q == V_W'(V_TOT - 1));
        h_d     = h_last ? '0 : h_q + 1'b1;
        v_d     = v_q;
        if (h_last) begin
            v_d = v_last ? '0 : v_q + 1'b1;
        end
        hd_e_d  = (h_q >= H_W'(T_H_SYNC));
        vd_e_d  = (v_q >= V_W'(T_V_SYNC));
        req_d   = (h_q >= H_W'(H_ST)) && (h_q < H_W'(H_ST + T_H_ACTIVE))
               && (v_q >= V_W'(V_ST)) && (v_q < V_W'(V_ST + T_V_ACTIVE));
        x_d     = req_d ? X_W'(h_q - H_W'(H_ST)) : '0;
        y_d     = req_d ? Y_W'(v_q - V_W'(V_ST)) : '0;
        frame_d = (h_q == '0) && (v_q == '0);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ph_q    <= 1'b0;
            grest_q <= 1'b0;
            h_q     <= '0;
            v_q     <= '0;
            hd_e_q  <= 1'b1;
            vd_e_q  <= 1'b1;
            req_q   <= 1'b0;
            frame_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            ph_q    <= ~ph_q;
            grest_q <= 1'b1;
            if (ph_q) begin
                h_q     <= h_d;
                v_q     <= v_d;
                hd_e_q  <= hd_e_d;
                vd_e_q  <= vd_e_d;
                req_q   <= req_d;
                frame_q <= frame_d;
                x_q     <= x_d;
                y_q     <= y_d;
            end
        end
    end

    assign early = '{hd: hd_e_q, vd: vd_e_q, den: req_q};

    lcd_delay_line #(
        .DEPTH (T_LAT),
        .WIDTH ($bits(ctrl_t)),
        .FILL  (CTRL_IDLE)
    ) u_align (
        .clk_i (CLK),
        .rst_i (RST),
        .en_i  (ph_q),
        .d_i   (early),
        .q_o   (late)
    );

    assign NCLK   = ph_q;
    assign PIX_EN = ph_q;
    assign GREST  = grest_q;
    assign HD     = late.hd;
    assign VD     = late.vd;
    assign DEN    = late.den;
    assign REQ    = req_q;
    assign X      = x_q;
    assign Y      = y_q;
    assign FRAME  = frame_q;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench: default-timing instance plus two shrunken-raster instances
// (LAT=2 and LAT=0) so wrap and frame behaviour fit in a short run.
module tb_lcd_timing_gen;

  logic CLK = 1'b0;
  logic RST_D = 1'b1;
  logic RST_S = 1'b1;

  always #5 CLK = ~CLK;

  logic       d_nclk, d_pix, d_grest, d_hd, d_vd, d_den, d_req, d_frame;
  logic [9:0] d_x;
  logic [8:0] d_y;
  logic       s_nclk, s_pix, s_grest, s_hd, s_vd, s_den, s_req, s_frame;
  logic [9:0] s_x;
  logic [8:0] s_y;
  logic       z_nclk, z_pix, z_grest, z_hd, z_vd, z_den, z_req, z_frame;
  logic [9:0] z_x;
  logic [8:0] z_y;

  lcd_timing_gen dut_d (
    .CLK(CLK), .RST(RST_D), .NCLK(d_nclk), .PIX_EN(d_pix), .GREST(d_grest),
    .HD(d_hd), .VD(d_vd), .DEN(d_den), .REQ(d_req), .X(d_x), .Y(d_y), .FRAME(d_frame)
  );

  // Small raster: H_TOTAL=14 (start 3), V_TOTAL=8 (start 3), frame = 112 ticks.
  lcd_timing_gen #(
    .T_H_ACTIVE(8), .T_H_FRONT(3), .T_H_SYNC(1), .T_H_BACK(2),
    .T_V_ACTIVE(4), .T_V_FRONT(1), .T_V_SYNC(1), .T_V_BACK(2), .T_LAT(2)
  ) dut_s (
    .CLK(CLK), .RST(RST_S), .NCLK(s_nclk), .PIX_EN(s_pix), .GREST(s_grest),
    .HD(s_hd), .VD(s_vd), .DEN(s_den), .REQ(s_req), .X(s_x), .Y(s_y), .FRAME(s_frame)
  );

  lcd_timing_gen #(
    .T_H_ACTIVE(8), .T_H_FRONT(3), .T_H_SYNC(1), .T_H_BACK(2),
    .T_V_ACTIVE(4), .T_V_FRONT(1), .T_V_SYNC(1), .T_V_BACK(2), .T_LAT(0)
  ) dut_z (
    .CLK(CLK), .RST(RST_S), .NCLK(z_nclk), .PIX_EN(z_pix), .GREST(z_grest),
    .HD(z_hd), .VD(z_vd), .DEN(z_den), .REQ(z_req), .X(z_x), .Y(z_y), .FRAME(z_frame)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int k        = 0;

  // DEN burst monitor on the small LAT=2 instance.
  int   bursts;
  int   den_hi;
  logic den_prev;

  always @(negedge CLK) begin
    if (RST_S) begin
      bursts   <= 0;
      den_hi   <= 0;
      den_prev <= 1'b0;
    end else begin
      den_prev <= s_den;
      if (s_den && !den_prev) bursts <= bursts + 1;
      if (s_den) den_hi <= den_hi + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s @k=%0d: observed %0h expected %0h", tag, k, obs, exp);
    end
  endtask

  // Lands #1 after clock edge number 'target' counted from reset release.
  task automatic goto(input int target);
    repeat (target - k) @(posedge CLK);
    #1;
    k = target;
  endtask

  initial begin
    repeat (20) @(posedge CLK);
    #1;
    check("rst_nclk",  32'(d_nclk),  0);
    check("rst_pixen", 32'(d_pix),   0);
    check("rst_grest", 32'(d_grest), 0);
    check("rst_hd",    32'(d_hd),    1);
    check("rst_vd",    32'(d_vd),    1);
    check("rst_den",   32'(d_den),   0);
    check("rst_req",   32'(d_req),   0);
    check("rst_x",     32'(d_x),     0);
    check("rst_y",     32'(d_y),     0);
    check("rst_frame", 32'(d_frame), 0);
    check("rst_s_hd",  32'(s_hd),    1);
    check("rst_z_den", 32'(z_den),   0);
    RST_D = 1'b0;
    RST_S = 1'b0;
    k = 0;

    // Clock phase and first ticks.
    goto(1);
    check("grest_rise", 32'(d_grest), 1);
    check("nclk_k1",    32'(d_nclk),  1);
    check("pixen_k1",   32'(d_pix),   1);
    check("frame_k1",   32'(d_frame), 0);
    goto(2);
    check("nclk_k2",    32'(d_nclk),  0);
    check("pixen_k2",   32'(d_pix),   0);
    check("frame_k2",   32'(d_frame), 1);
    check("req_k2",     32'(d_req),   0);
    check("hd_k2",      32'(d_hd),    1);
    check("z_hd_k2",    32'(z_hd),    0);
    goto(3);
    check("nclk_k3",    32'(d_nclk),  1);
    check("frame_k3",   32'(d_frame), 1);
    goto(4);
    check("frame_k4",   32'(d_frame), 0);
    check("pixen_k4",   32'(d_pix),   0);
    check("z_hd_k4",    32'(z_hd),    1);
    goto(5);
    check("hd_k5",      32'(d_hd),    1);
    check("vd_k5",      32'(d_vd),    1);
    goto(6);
    check("hd_k6",      32'(d_hd),    0);
    check("vd_k6",      32'(d_vd),    0);
    check("s_hd_k6",    32'(s_hd),    0);
    goto(7);
    check("hd_k7",      32'(d_hd),    0);
    goto(8);
    check("hd_k8",      32'(d_hd),    1);
    check("vd_k8",      32'(d_vd),    0);

    // Small raster: first active pixel h=3,v=3 is tick 45.
    goto(91);
    check("s_req_k91",  32'(s_req),   0);
    check("s_den_k91",  32'(s_den),   0);
    check("z_den_k91",  32'(z_den),   0);
    goto(92);
    check("s_req_k92",  32'(s_req),   1);
    check("s_x_first",  32'(s_x),     0);
    check("s_y_first",  32'(s_y),     0);
    check("s_den_k92",  32'(s_den),   0);
    check("z_den_k92",  32'(z_den),   1);
    goto(94);
    check("s_x_k94",    32'(s_x),     1);
    goto(95);
    check("s_den_k95",  32'(s_den),   0);
    goto(96);
    check("s_den_rise", 32'(s_den),   1);
    goto(106);
    check("s_x_eol",    32'(s_x),     7);
    check("s_y_k106",   32'(s_y),     0);
    goto(108);
    check("s_req_fp",   32'(s_req),   0);
    check("s_x_fp",     32'(s_x),     0);
    check("z_den_fp",   32'(z_den),   0);
    goto(120);
    check("s_y_line1",  32'(s_y),     1);
    check("s_x_line1",  32'(s_x),     0);
    goto(190);
    check("s_req_last", 32'(s_req),   1);
    check("s_x_last",   32'(s_x),     7);
    check("s_y_last",   32'(s_y),     3);
    goto(192);
    check("s_req_k192", 32'(s_req),   0);
    check("s_y_k192",   32'(s_y),     0);

    // Wrap from h=13,v=7 to h=0,v=0.
    goto(225);
    check("s_frame_k225", 32'(s_frame), 0);
    goto(226);
    check("s_frame_k226", 32'(s_frame), 1);
    goto(227);
    check("s_frame_k227", 32'(s_frame), 1);
    goto(228);
    check("s_frame_k228", 32'(s_frame), 0);
    goto(229);
    check("s_hd_k229",  32'(s_hd),    1);
    check("s_vd_k229",  32'(s_vd),    1);
    check("s_bursts",   32'(bursts),  4);
    check("s_den_hi",   32'(den_hi),  64);
    goto(230);
    check("s_hd_wrap",  32'(s_hd),    0);
    check("s_vd_wrap",  32'(s_vd),    0);
    goto(232);
    check("s_hd_k232",  32'(s_hd),    1);

    // Mid-line reset during active video (h=6, v=3 of frame 1).
    goto(322);
    check("s_req_k322", 32'(s_req),   1);
    check("s_x_k322",   32'(s_x),     3);
    check("s_den_k322", 32'(s_den),   1);
    RST_S = 1'b1;
    goto(323);
    check("mr_den",     32'(s_den),   0);
    check("mr_hd",      32'(s_hd),    1);
    check("mr_vd",      32'(s_vd),    1);
    check("mr_x",       32'(s_x),     0);
    check("mr_y",       32'(s_y),     0);
    check("mr_req",     32'(s_req),   0);
    check("mr_nclk",    32'(s_nclk),  0);
    check("mr_grest",   32'(s_grest), 0);
    check("mr_z_den",   32'(z_den),   0);
    RST_S = 1'b0;
    goto(324);
    check("mr_grest_up", 32'(s_grest), 1);
    check("mr_nclk_k324", 32'(s_nclk), 1);
    goto(325);
    check("mr_frame",   32'(s_frame), 1);
    goto(328);
    check("mr_vd_k328", 32'(s_vd),    1);
    goto(329);
    check("mr_vd_k329", 32'(s_vd),    0);
    goto(552);
    check("mr_vd_k552", 32'(s_vd),    1);
    goto(553);
    check("mr_vd_next", 32'(s_vd),    0);

    // Default raster: second line HD and VD end.
    goto(2117);
    check("hd_k2117",   32'(d_hd),    1);
    check("vd_k2117",   32'(d_vd),    0);
    goto(2118);
    check("hd_line1",   32'(d_hd),    0);
    check("vd_line1",   32'(d_vd),    1);
    goto(2119);
    check("hd_k2119",   32'(d_hd),    0);
    goto(2120);
    check("hd_k2120",   32'(d_hd),    1);

    // Default raster: first active pixel h=46,v=23 is tick 24334.
    goto(48669);
    check("req_k48669", 32'(d_req),   0);
    goto(48670);
    check("req_first",  32'(d_req),   1);
    check("x_first",    32'(d_x),     0);
    check("y_first",    32'(d_y),     0);
    check("den_k48670", 32'(d_den),   0);
    goto(48672);
    check("x_k48672",   32'(d_x),     1);
    goto(48673);
    check("den_k48673", 32'(d_den),   0);
    goto(48674);
    check("den_rise",   32'(d_den),   1);
    check("x_k48674",   32'(d_x),     2);

    // Mid-line reset on the default instance.
    RST_D = 1'b1;
    goto(48675);
    check("dmr_den",    32'(d_den),   0);
    check("dmr_hd",     32'(d_hd),    1);
    check("dmr_vd",     32'(d_vd),    1);
    check("dmr_x",      32'(d_x),     0);
    check("dmr_y",      32'(d_y),     0);
    check("dmr_req",    32'(d_req),   0);
    RST_D = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
